// File: rtl/writeback_arbiter.sv
// Merges ALU/load results and buffered MDU results onto the single register-file write port.
// Optional feature: define WB_BYPASS_EN to let an MDU result skip the empty FIFO when the ALU is idle.
module writeback_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    input  logic [4:0]      query_rd,
    output logic            query_hit,
    output logic            stall_req,
    output logic            reg_write,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_CNT = SW'(STARVE_LIMIT);

    logic [4:0]            fifo_rd_r   [FIFO_DEPTH];
    logic [XLEN-1:0]       fifo_data_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld_r;
    logic [FIFO_DEPTH-1:0] vld_nxt_s;
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;
    logic [SW-1:0]         starve_cnt_r;
    logic [SW-1:0]         starve_nxt_s;
    logic                  stall_req_r;
    logic                  reg_write_r;
    logic [4:0]            write_reg_r;
    logic [XLEN-1:0]       write_data_r;

    logic                  xfer_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  bypass_s;
    logic                  fifo_empty_s;
    logic                  hit_s;
    logic                  we_nxt_s;
    logic [4:0]            wreg_nxt_s;
    logic [XLEN-1:0]       wdata_nxt_s;

    assign mdu_ready    = (count_r != FULL_CNT);
    assign fifo_empty_s = (count_r == {(AW + 1){1'b0}});
    assign xfer_s       = mdu_valid && mdu_ready;
    // The ALU always wins; the FIFO only drains into ALU-idle cycles.
    assign pop_s        = !alu_valid && !fifo_empty_s;

`ifdef WB_BYPASS_EN
    assign bypass_s = xfer_s && (mdu_rd != 5'd0) && fifo_empty_s && !alu_valid;
`else
    assign bypass_s = 1'b0;
`endif

    // rd = 0 results complete the handshake but never occupy a slot.
    assign push_s = xfer_s && (mdu_rd != 5'd0) && !bypass_s;

    assign vld_nxt_s = (fifo_vld_r | ({{(FIFO_DEPTH - 1){1'b0}}, push_s} << wr_ptr_r))
                     & ~({{(FIFO_DEPTH - 1){1'b0}}, pop_s} << rd_ptr_r);

    // FIFO payload storage; slot contents are qualified by fifo_vld_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_rd_r[wr_ptr_r]   <= mdu_rd;
            fifo_data_r[wr_ptr_r] <= mdu_data;
        end
    end

    // FIFO pointers, occupancy and per-slot valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW + 1){1'b0}};
            fifo_vld_r <= {FIFO_DEPTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r    <= count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
            fifo_vld_r <= vld_nxt_s;
        end
    end

    // Next write-port contents by fixed priority: ALU, FIFO head, bypassed MDU, idle.
    always_comb begin
        we_nxt_s    = 1'b0;
        wreg_nxt_s  = 5'd0;
        wdata_nxt_s = {XLEN{1'b0}};
        if (alu_valid) begin
            if (alu_rd != 5'd0) begin
                we_nxt_s    = 1'b1;
                wreg_nxt_s  = alu_rd;
                wdata_nxt_s = alu_data;
            end else begin
                we_nxt_s    = 1'b0;
            end
        end else if (pop_s) begin
            we_nxt_s    = 1'b1;
            wreg_nxt_s  = fifo_rd_r[rd_ptr_r];
            wdata_nxt_s = fifo_data_r[rd_ptr_r];
        end else if (bypass_s) begin
            we_nxt_s    = 1'b1;
            wreg_nxt_s  = mdu_rd;
            wdata_nxt_s = mdu_data;
        end else begin
            we_nxt_s    = 1'b0;
        end
    end

    // Starvation count: only grows while something is queued and the ALU keeps winning.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (fifo_empty_s) begin
            starve_nxt_s = {SW{1'b0}};
        end else if (pop_s) begin
            starve_nxt_s = {SW{1'b0}};
        end else if (starve_cnt_r == LIMIT_CNT) begin
            starve_nxt_s = LIMIT_CNT;
        end else begin
            starve_nxt_s = starve_cnt_r + 1'b1;
        end
    end

    // Output stage and starvation state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= 5'd0;
            write_data_r <= {XLEN{1'b0}};
            starve_cnt_r <= {SW{1'b0}};
            stall_req_r  <= 1'b0;
        end else begin
            reg_write_r  <= we_nxt_s;
            write_reg_r  <= wreg_nxt_s;
            write_data_r <= wdata_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            stall_req_r  <= (starve_nxt_s == LIMIT_CNT);
        end
    end

    // Pending-write lookup for the hazard unit.
    always_comb begin
        hit_s = reg_write_r && (write_reg_r == query_rd);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            hit_s = hit_s | (fifo_vld_r[i] && (fifo_rd_r[i] == query_rd));
        end
    end

    assign query_hit  = hit_s && (query_rd != 5'd0);
    assign stall_req  = stall_req_r;
    assign reg_write  = reg_write_r;
    assign write_reg  = write_reg_r;
    assign write_data = write_data_r;

endmodule
